set_assoc_cache: RTL and testbench

SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

---
 rtl/cache_pkg.sv | 28 ++
 rtl/set_assoc_cache_if.sv | 34 +++
 rtl/cache_way.sv | 58 +++++
 rtl/set_assoc_cache.sv | 162 ++++++++++++++++
 tb/tb_set_assoc_cache.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared types and address-field width helpers for the set-associative cache.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE_TAG,
        WRITE_BACK,
        ALLOCATE
    } state_t;

    function automatic int off_bits(input int words);
        return $clog2(words);
    endfunction

    function automatic int idx_bits(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_bits(input int sets, input int words);
        return 30 - off_bits(words) - idx_bits(sets);
    endfunction

    // Select width never drops to zero so 1-entry choices still get a port.
    function automatic int sel_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/set_assoc_cache_if.sv
// CPU-side and memory-side buses of the cache, bundled with role modports.
interface set_assoc_cache_if #(
    parameter int WORDS = 4
);
    localparam int LINE_W = 32 * WORDS;

    logic              cpu2cache_valid;
    logic              cpu2cache_rw;
    logic [31:0]       cpu2cache_addr;
    logic [31:0]       cpu2cache_data;
    logic [31:0]       cache2cpu_data;
    logic              cache2cpu_ready;
    logic              cache2mem_valid;
    logic              cache2mem_rw;
    logic [31:0]       cache2mem_addr;
    logic [LINE_W-1:0] cache2mem_data;
    logic [LINE_W-1:0] mem2cache_data;
    logic              mem2cache_ready;

    modport slave (
        input  cpu2cache_valid, cpu2cache_rw, cpu2cache_addr, cpu2cache_data,
        input  mem2cache_data, mem2cache_ready,
        output cache2cpu_data, cache2cpu_ready,
        output cache2mem_valid, cache2mem_rw, cache2mem_addr, cache2mem_data
    );

    modport master (
        output cpu2cache_valid, cpu2cache_rw, cpu2cache_addr, cpu2cache_data,
        output mem2cache_data, mem2cache_ready,
        input  cache2cpu_data, cache2cpu_ready,
        input  cache2mem_valid, cache2mem_rw, cache2mem_addr, cache2mem_data
    );

endinterface

// File: rtl/cache_way.sv
// One cache way: per-set tag/line storage, valid/dirty flags, tag compare.
module cache_way #(
    parameter int SETS  = 1024,
    parameter int WORDS = 4,
    parameter int IDXW  = 10,
    parameter int TAGW  = 18,
    parameter int WSW   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IDXW-1:0]       i_idx,
    input  logic [TAGW-1:0]       i_tag,
    input  logic [WSW-1:0]        i_word,
    input  logic [31:0]           i_wdata,
    input  logic                  i_wr,
    input  logic                  i_fill,
    input  logic [32*WORDS-1:0]   i_fill_line,
    output logic                  o_hit,
    output logic                  o_valid,
    output logic                  o_dirty,
    output logic [TAGW-1:0]       o_tag,
    output logic [32*WORDS-1:0]   o_line
);

    logic [TAGW-1:0]     r_tag  [SETS];
    logic [32*WORDS-1:0] r_data [SETS];
    logic [SETS-1:0]     r_valid;
    logic [SETS-1:0]     r_dirty;

    assign o_valid = r_valid[i_idx];
    assign o_dirty = r_dirty[i_idx];
    assign o_tag   = r_tag[i_idx];
    assign o_line  = r_data[i_idx];
    assign o_hit   = o_valid && (r_tag[i_idx] == i_tag);

    // Tag and data storage carry no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (i_fill) begin
            r_tag[i_idx]  <= i_tag;
            r_data[i_idx] <= i_fill_line;
        end else if (i_wr) begin
            r_data[i_idx][32*i_word +: 32] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_fill) begin
            r_valid[i_idx] <= 1'b1;
            r_dirty[i_idx] <= 1'b0;
        end else if (i_wr) begin
            r_dirty[i_idx] <= 1'b1;
        end
    end

endmodule

// File: rtl/set_assoc_cache.sv
// Write-back, write-allocate set-associative cache with round-robin refill.
module set_assoc_cache
    import cache_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int SETS  = 1024,
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    r,
    set_assoc_cache_if.slave        bus,
    output logic [31:0]             hit_count,
    output logic [31:0]             miss_count
);

    localparam int OFFW   = off_bits(WORDS);
    localparam int IDXW   = idx_bits(SETS);
    localparam int TAGW   = tag_bits(SETS, WORDS);
    localparam int WSW    = sel_bits(WORDS);
    localparam int PW     = sel_bits(WAYS);
    localparam int LINE_W = 32 * WORDS;
    localparam int LSB    = 2 + OFFW;

    state_t          r_state, w_next;
    logic [31:2]     r_addr;
    logic            r_rw;
    logic [31:0]     r_wdata;
    logic            r_refill;
    logic [PW-1:0]   r_victim;
    logic [PW-1:0]   r_rr [SETS];
    logic [31:0]     r_hits, r_miss;

    logic [IDXW-1:0]   w_idx;
    logic [TAGW-1:0]   w_tag;
    logic [WSW-1:0]    w_word;
    logic [WAYS-1:0]   w_hit, w_vld, w_drt, w_wr, w_fill;
    logic [TAGW-1:0]   w_vtag [WAYS];
    logic [LINE_W-1:0] w_line [WAYS];
    logic              w_any;
    logic [PW-1:0]     w_hway, w_victim;
    logic [LINE_W-1:0] w_hline;
    logic              w_mem_done;

    assign w_idx      = r_addr[LSB +: IDXW];
    assign w_tag      = r_addr[31 -: TAGW];
    assign w_mem_done = (r_state == ALLOCATE) && bus.mem2cache_ready;
    assign hit_count  = r_hits;
    assign miss_count = r_miss;

    if (WORDS > 1) begin : g_wsel
        assign w_word = r_addr[2 +: WSW];
    end else begin : g_wsel1
        assign w_word = '0;
    end

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        assign w_wr[g]   = (r_state == COMPARE_TAG) && w_any && r_rw
                         && (w_hway == PW'(g));
        assign w_fill[g] = w_mem_done && (r_victim == PW'(g));
        cache_way #(
            .SETS(SETS), .WORDS(WORDS), .IDXW(IDXW), .TAGW(TAGW), .WSW(WSW)
        ) u_way (
            .clk(clk), .rst(r),
            .i_idx(w_idx), .i_tag(w_tag), .i_word(w_word),
            .i_wdata(r_wdata), .i_wr(w_wr[g]),
            .i_fill(w_fill[g]), .i_fill_line(bus.mem2cache_data),
            .o_hit(w_hit[g]), .o_valid(w_vld[g]), .o_dirty(w_drt[g]),
            .o_tag(w_vtag[g]), .o_line(w_line[g])
        );
    end

    // Victim: lowest invalid way, otherwise the set's round-robin pick.
    always_comb begin
        w_any    = |w_hit;
        w_hway   = '0;
        w_hline  = w_line[0];
        w_victim = r_rr[w_idx];
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_hway  = PW'(i);
                w_hline = w_line[i];
            end
            if (!w_vld[i]) w_victim = PW'(i);
        end
    end

    always_comb begin
        w_next              = r_state;
        bus.cache2cpu_ready = 1'b0;
        bus.cache2cpu_data  = '0;
        bus.cache2mem_valid = 1'b0;
        bus.cache2mem_rw    = 1'b0;
        bus.cache2mem_addr  = '0;
        bus.cache2mem_data  = '0;
        unique case (r_state)
            IDLE: begin
                if (bus.cpu2cache_valid) w_next = COMPARE_TAG;
            end
            COMPARE_TAG: begin
                if (w_any) begin
                    bus.cache2cpu_ready = 1'b1;
                    if (!r_rw) bus.cache2cpu_data = w_hline[32*w_word +: 32];
                    w_next = IDLE;
                end else if (w_vld[w_victim] && w_drt[w_victim]) begin
                    w_next = WRITE_BACK;
                end else begin
                    w_next = ALLOCATE;
                end
            end
            WRITE_BACK: begin
                bus.cache2mem_valid = 1'b1;
                bus.cache2mem_rw    = 1'b1;
                bus.cache2mem_addr  = {w_vtag[r_victim], w_idx, {LSB{1'b0}}};
                bus.cache2mem_data  = w_line[r_victim];
                if (bus.mem2cache_ready) w_next = ALLOCATE;
            end
            ALLOCATE: begin
                bus.cache2mem_valid = 1'b1;
                bus.cache2mem_addr  = {w_tag, w_idx, {LSB{1'b0}}};
                if (bus.mem2cache_ready) w_next = COMPARE_TAG;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_rw     <= 1'b0;
            r_wdata  <= '0;
            r_refill <= 1'b0;
            r_victim <= '0;
            r_hits   <= '0;
            r_miss   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && bus.cpu2cache_valid) begin
                r_addr   <= bus.cpu2cache_addr[31:2];
                r_rw     <= bus.cpu2cache_rw;
                r_wdata  <= bus.cpu2cache_data;
                r_refill <= 1'b0;
            end
            // Only the first tag compare of a request is counted.
            if (r_state == COMPARE_TAG) begin
                r_victim <= w_victim;
                if (!r_refill && w_any && !(&r_hits)) r_hits <= r_hits + 1'b1;
                if (!r_refill && !w_any && !(&r_miss)) r_miss <= r_miss + 1'b1;
            end
            if (w_mem_done) r_refill <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
        end else if (w_mem_done) begin
            r_rr[w_idx] <= (r_rr[w_idx] == PW'(WAYS - 1)) ? '0 : r_rr[w_idx] + 1'b1;
        end
    end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed scoreboard bench for set_assoc_cache (2 ways, 1024 sets, 4 words).
module tb_set_assoc_cache;

    logic        clk = 1'b0;
    logic        r   = 1'b1;
    logic [31:0] hit_count, miss_count;
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] exp_q [$];
    logic [127:0] wb;

    localparam logic [127:0] L1 = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    localparam logic [127:0] L2 = 128'h8888_8888_7777_7777_6666_6666_5555_5555;
    localparam logic [127:0] L3 = 128'hCCCC_CCCC_BBBB_BBBB_AAAA_AAAA_9999_9999;
    localparam logic [127:0] L4 = 128'h0404_0404_0303_0303_0202_0202_0101_0101;
    localparam logic [127:0] WBL = 128'h4444_4444_3333_3333_DEAD_BEEF_1111_1111;

    set_assoc_cache_if #(.WORDS(4)) bus ();

    set_assoc_cache #(.WAYS(2), .SETS(1024), .WORDS(4)) dut (
        .clk(clk), .r(r), .bus(bus),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_req(input logic rw, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] exp);
        bus.cpu2cache_valid = 1'b1;
        bus.cpu2cache_rw    = rw;
        bus.cpu2cache_addr  = addr;
        bus.cpu2cache_data  = wd;
        if (!rw) exp_q.push_back(exp);
        @(negedge clk);
        bus.cpu2cache_valid = 1'b0;
    endtask

    task automatic wait_resp(input string tag, input logic rw);
        int i = 0;
        logic [31:0] e;
        while (!bus.cache2cpu_ready && i < 40) begin
            @(negedge clk);
            i++;
        end
        chk({tag, "_ready"}, bus.cache2cpu_ready, 1'b1);
        if (!rw && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (bus.cache2cpu_ready) chk({tag, "_data"}, bus.cache2cpu_data, e);
        end
        @(negedge clk);
        chk({tag, "_ready_1cyc"}, bus.cache2cpu_ready, 1'b0);
    endtask

    task automatic mem_serve(input string tag, input logic rw,
                             input logic [31:0] addr, input int delay,
                             input logic toggle, input logic [127:0] line,
                             output logic [127:0] wdat);
        int i = 0;
        logic [31:0]  a0;
        logic [127:0] d0;
        while (!bus.cache2mem_valid && i < 40) begin
            @(negedge clk);
            i++;
        end
        chk({tag, "_valid"}, bus.cache2mem_valid, 1'b1);
        chk({tag, "_rw"}, bus.cache2mem_rw, rw);
        chk({tag, "_addr"}, bus.cache2mem_addr, addr);
        wdat = bus.cache2mem_data;
        a0 = bus.cache2mem_addr;
        d0 = bus.cache2mem_data;
        for (int k = 0; k < delay; k++) begin
            if (toggle) begin
                bus.cpu2cache_valid = ~bus.cpu2cache_valid;
                bus.cpu2cache_rw    = 1'b1;
                bus.cpu2cache_addr  = 32'h0000_0014;
                bus.cpu2cache_data  = 32'h0BAD_0BAD;
            end
            @(negedge clk);
            chk({tag, "_hold_valid"}, bus.cache2mem_valid, 1'b1);
            chk({tag, "_hold_addr"}, bus.cache2mem_addr, a0);
            chk({tag, "_hold_data"}, bus.cache2mem_data, d0);
            chk({tag, "_hold_noready"}, bus.cache2cpu_ready, 1'b0);
        end
        bus.cpu2cache_valid = 1'b0;
        bus.mem2cache_ready = 1'b1;
        bus.mem2cache_data  = line;
        @(negedge clk);
        bus.mem2cache_ready = 1'b0;
        bus.mem2cache_data  = '0;
    endtask

    initial begin
        int i;
        bus.cpu2cache_valid = 1'b0;
        bus.cpu2cache_rw    = 1'b0;
        bus.cpu2cache_addr  = '0;
        bus.cpu2cache_data  = '0;
        bus.mem2cache_ready = 1'b0;
        bus.mem2cache_data  = '0;

        #2;
        chk("rst_ready", bus.cache2cpu_ready, 1'b0);
        chk("rst_cpu_data", bus.cache2cpu_data, 32'h0);
        chk("rst_mem_valid", bus.cache2mem_valid, 1'b0);
        chk("rst_mem_addr", bus.cache2mem_addr, 32'h0);
        chk("rst_hits", hit_count, 32'h0);
        chk("rst_miss", miss_count, 32'h0);
        @(negedge clk);
        @(negedge clk);
        r = 1'b0;
        @(negedge clk);

        // Cold read miss, refill, word 0 returned.
        start_req(1'b0, 32'h0000_0010, 32'h0, 32'h1111_1111);
        chk("A_miss_noready", bus.cache2cpu_ready, 1'b0);
        chk("A_cmp_nomem", bus.cache2mem_valid, 1'b0);
        mem_serve("A_alloc", 1'b0, 32'h0000_0010, 0, 1'b0, L1, wb);
        wait_resp("A", 1'b0);
        chk("A_miss_cnt", miss_count, 32'd1);
        chk("A_hit_cnt", hit_count, 32'd0);

        // Write hit then read hit, each one cycle after acceptance.
        start_req(1'b1, 32'h0000_0014, 32'hDEAD_BEEF, 32'h0);
        chk("B_wr_latency", bus.cache2cpu_ready, 1'b1);
        chk("B_wr_nomem", bus.cache2mem_valid, 1'b0);
        wait_resp("B_wr", 1'b1);
        start_req(1'b0, 32'h0000_0014, 32'h0, 32'hDEAD_BEEF);
        chk("B_rd_latency", bus.cache2cpu_ready, 1'b1);
        chk("B_rd_nomem", bus.cache2mem_valid, 1'b0);
        wait_resp("B_rd", 1'b0);
        chk("B_hit_cnt", hit_count, 32'd2);

        // Fill second way of set 1.
        start_req(1'b0, 32'h0000_4010, 32'h0, 32'h5555_5555);
        chk("C_miss_noready", bus.cache2cpu_ready, 1'b0);
        mem_serve("C_alloc", 1'b0, 32'h0000_4010, 0, 1'b0, L2, wb);
        wait_resp("C", 1'b0);

        // Evict dirty way 0, CPU noise during write-back, slow refill.
        start_req(1'b0, 32'h0000_8010, 32'h0, 32'h9999_9999);
        mem_serve("D_wb", 1'b1, 32'h0000_0010, 3, 1'b1, '0, wb);
        chk("D_wb_line", wb, WBL);
        mem_serve("D_alloc", 1'b0, 32'h0000_8010, 5, 1'b0, L3, wb);
        wait_resp("D", 1'b0);
        chk("D_miss_cnt", miss_count, 32'd3);
        chk("D_hit_cnt", hit_count, 32'd2);

        // Way 1 survived the eviction.
        start_req(1'b0, 32'h0000_4010, 32'h0, 32'h5555_5555);
        chk("E_latency", bus.cache2cpu_ready, 1'b1);
        wait_resp("E", 1'b0);
        chk("E_hit_cnt", hit_count, 32'd3);

        // Reset in the middle of a refill.
        start_req(1'b0, 32'h0000_C010, 32'h0, 32'h0);
        i = 0;
        while (!bus.cache2mem_valid && i < 40) begin
            @(negedge clk);
            i++;
        end
        chk("F_alloc_valid", bus.cache2mem_valid, 1'b1);
        chk("F_alloc_addr", bus.cache2mem_addr, 32'h0000_C010);
        @(negedge clk);
        r = 1'b1;
        #1;
        chk("F_rst_mem_valid", bus.cache2mem_valid, 1'b0);
        chk("F_rst_mem_addr", bus.cache2mem_addr, 32'h0);
        chk("F_rst_ready", bus.cache2cpu_ready, 1'b0);
        chk("F_rst_hits", hit_count, 32'h0);
        chk("F_rst_miss", miss_count, 32'h0);
        exp_q.delete();
        @(negedge clk);
        r = 1'b0;
        @(negedge clk);

        // Same address must miss again after the abandoned refill.
        start_req(1'b0, 32'h0000_C010, 32'h0, 32'h0101_0101);
        chk("G_miss_noready", bus.cache2cpu_ready, 1'b0);
        mem_serve("G_alloc", 1'b0, 32'h0000_C010, 0, 1'b0, L4, wb);
        wait_resp("G", 1'b0);
        chk("G_miss_cnt", miss_count, 32'd1);
        chk("G_hit_cnt", hit_count, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
